// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the DB15 serial joystick receiver.
// Bit positions describe the active-high button word handed to the core.
package joy_serial_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LOAD,
    ST_LO,
    ST_HI,
    ST_DONE
  } joy_state_e;

  localparam int FRAME_BITS  = 32;
  localparam int PLAYER_BITS = 16;
  localparam int USED_BITS   = 12;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_D      = 7;
  localparam int BTN_E      = 8;
  localparam int BTN_F      = 9;
  localparam int BTN_START  = 10;
  localparam int BTN_SELECT = 11;

  // Keep only the wired buttons of one player's half-frame.
  function automatic logic [PLAYER_BITS-1:0] player_word(input logic [PLAYER_BITS-1:0] r);
    return {{(PLAYER_BITS-USED_BITS){1'b0}}, r[USED_BITS-1:0]};
  endfunction

endpackage

// File: rtl/joy_tick_div.sv
// Free-running divider producing a one-clk tick every DIV clocks.
// The tick is combinational off the count so the FSM moves on the wrap edge.
module joy_tick_div #(
  parameter int DIV = 24
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/joy_serial_db15_rx.sv
// DB15 two-player serial joystick receiver: loads the adapter's shift register,
// clocks in a 32-bit active-low frame and publishes filtered active-high words.
module joy_serial_db15_rx
  import joy_serial_pkg::*;
#(
  parameter int DIV        = 24,
  parameter int WAIT_TICKS = 1000,
  parameter int STABLE     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        present,
  output logic        frame_done,
  output joy_state_e  dbg_state
);

  localparam int WCW = $clog2(WAIT_TICKS + 2);

  // Handshake: none; the adapter is a passive shift register driven open-loop.
  logic                  tick;
  joy_state_e            state_q, state_d;
  logic [WCW-1:0]        tcnt_q, tcnt_d;
  logic [4:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] raw_q, raw_d, prev_q, prev_d;
  logic [15:0]           joy1_q, joy1_d, joy2_q, joy2_d;
  logic                  joy_clk_q, joy_clk_d, joy_load_q, joy_load_d;
  logic                  present_q, present_d, frame_done_q, frame_done_d;

  joy_tick_div #(.DIV(DIV)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bit_d        = bit_q;
    raw_d        = raw_q;
    prev_d       = prev_q;
    joy1_d       = joy1_q;
    joy2_d       = joy2_q;
    present_d    = present_q;
    frame_done_d = 1'b0;
    // Pin levels follow the current state, so they lag a state change by one clk.
    joy_clk_d    = (state_q != ST_LO);
    joy_load_d   = (state_q != ST_LOAD);
    case (state_q)
      ST_WAIT: if (tick) begin
        if (tcnt_q == WCW'(WAIT_TICKS - 1)) begin
          tcnt_d  = '0;
          bit_d   = '0;
          state_d = ST_LOAD;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_LOAD: if (tick) begin
        if (tcnt_q == WCW'(1)) begin
          tcnt_d  = '0;
          state_d = ST_LO;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_LO: if (tick) begin
        raw_d[bit_q] = ~JOY_DATA;
        state_d      = ST_HI;
      end
      ST_HI: if (tick) begin
        if (bit_q == 5'd31) begin
          state_d = ST_DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_LO;
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        state_d      = ST_WAIT;
        // An all-pressed frame means nothing is driving the data line.
        if (&raw_q) begin
          present_d = 1'b0;
          joy1_d    = '0;
          joy2_d    = '0;
        end else begin
          present_d = 1'b1;
          if (STABLE == 0 || raw_q == prev_q) begin
            joy1_d = player_word(raw_q[15:0]);
            joy2_d = player_word(raw_q[31:16]);
          end
          prev_d = raw_q;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT;
      tcnt_q       <= '0;
      bit_q        <= '0;
      raw_q        <= '0;
      prev_q       <= '0;
      joy1_q       <= '0;
      joy2_q       <= '0;
      present_q    <= 1'b0;
      frame_done_q <= 1'b0;
      joy_clk_q    <= 1'b1;
      joy_load_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bit_q        <= bit_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
      present_q    <= present_d;
      frame_done_q <= frame_done_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
    end
  end

  assign JOY_CLK    = joy_clk_q;
  assign JOY_LOAD   = joy_load_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign present    = present_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_joy_serial_db15_rx.sv
// Bench for joy_serial_db15_rx: unfiltered and two-frame-filtered instances
// share one modelled DB15 adapter; directed frames with hand-computed words.
module tb_joy_serial_db15_rx;
  import joy_serial_pkg::*;

  localparam int DIV        = 4;
  localparam int WAIT_TICKS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic        jdata;
  logic        s0_clk, s0_load, s0_pres, s0_fd;
  logic        s1_clk, s1_load, s1_pres, s1_fd;
  logic [15:0] s0_j1, s0_j2, s1_j1, s1_j2;
  joy_state_e  s0_state, s1_state;

  joy_serial_db15_rx #(.DIV(DIV), .WAIT_TICKS(WAIT_TICKS), .STABLE(0)) u_s0 (
    .clk(clk), .reset_n(reset_n), .JOY_DATA(jdata), .JOY_CLK(s0_clk), .JOY_LOAD(s0_load),
    .joystick1(s0_j1), .joystick2(s0_j2), .present(s0_pres), .frame_done(s0_fd),
    .dbg_state(s0_state)
  );

  joy_serial_db15_rx #(.DIV(DIV), .WAIT_TICKS(WAIT_TICKS), .STABLE(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .JOY_DATA(jdata), .JOY_CLK(s1_clk), .JOY_LOAD(s1_load),
    .joystick1(s1_j1), .joystick2(s1_j2), .present(s1_pres), .frame_done(s1_fd),
    .dbg_state(s1_state)
  );

  // ---------------- adapter model ----------------
  logic [31:0] adapter_frame;  // active-high pressed buttons, raw bit order
  logic [31:0] sr = '1;
  logic        stuck_low;
  logic        jclk_prev = 1'b1, jload_prev = 1'b1;

  assign jdata = stuck_low ? 1'b0 : sr[0];

  always @(posedge clk) begin
    jclk_prev  <= s0_clk;
    jload_prev <= s0_load;
    if (!s0_load)                sr <= ~adapter_frame;
    else if (s0_clk && !jclk_prev) sr <= {1'b1, sr[31:1]};
  end

  // ---------------- frame monitors ----------------
  int cyc = 0, last_load_cyc = 0, period = 0, falls = 0, falls_last = 0;
  int fd_cyc = 0;
  logic glitch_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (jclk_prev && !s0_clk) falls <= falls + 1;
    if (jload_prev && !s0_load) begin
      period        <= cyc - last_load_cyc;
      last_load_cyc <= cyc;
      falls_last    <= falls;
      falls         <= 0;
    end
  end

  always @(negedge clk) if (s1_j1 == 16'h0001) glitch_seen <= 1'b1;

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (s0_fd !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    fd_cyc = cyc;
    check({tag, " frame_done"}, 32'(s0_fd), 32'd1);
  endtask

  task automatic frame_check(input string tag, input logic [15:0] a1, input logic [15:0] a2,
                             input logic [15:0] b1, input logic [15:0] b2, input logic pres);
    logic [63:0] e;
    exp_q.push_back({b2, b1, a2, a1});
    wait_frame(tag);
    e = exp_q.pop_front();
    check({tag, " s0_j1"}, 32'(s0_j1), 32'(e[15:0]));
    check({tag, " s0_j2"}, 32'(s0_j2), 32'(e[31:16]));
    check({tag, " s1_j1"}, 32'(s1_j1), 32'(e[47:32]));
    check({tag, " s1_j2"}, 32'(s1_j2), 32'(e[63:48]));
    check({tag, " s0_present"}, 32'(s0_pres), 32'(pres));
    check({tag, " s1_present"}, 32'(s1_pres), 32'(pres));
    check({tag, " s1_frame_done"}, 32'(s1_fd), 32'd1);
    @(negedge clk);
    check({tag, " fd_pulse_width"}, 32'(s0_fd), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rel_cyc;
    reset_n       = 1'b0;
    stuck_low     = 1'b0;
    adapter_frame = 32'h0400_0018;  // P1 Up+A, P2 Start
    repeat (5) @(negedge clk);
    check("rst JOY_CLK", 32'(s0_clk), 32'd1);
    check("rst JOY_LOAD", 32'(s0_load), 32'd1);
    check("rst j1", 32'(s0_j1), 32'd0);
    check("rst j2", 32'(s0_j2), 32'd0);
    check("rst present", 32'(s0_pres), 32'd0);
    check("rst frame_done", 32'(s0_fd), 32'd0);
    check("rst state", 32'(s0_state), 32'(ST_WAIT));

    reset_n = 1'b1;
    rel_cyc = cyc;
    n = 0;
    while (s0_load !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("first_load_clk_in_31_33", 32'(n >= 31 && n <= 33), 32'd1);

    frame_check("f1", 16'h0018, 16'h0400, 16'h0000, 16'h0000, 1'b1);
    check("first_update_latency_ok", 32'((fd_cyc - rel_cyc) >= 296 && (fd_cyc - rel_cyc) <= 298), 32'd1);
    frame_check("f2", 16'h0018, 16'h0400, 16'h0018, 16'h0400, 1'b1);
    check("frame_period", 32'(period), 32'd296);
    check("clk_falls_per_frame", 32'(falls_last), 32'd32);

    // One-frame glitch on P1 Right must not reach the filtered output.
    adapter_frame = 32'h0400_0001;
    frame_check("f3_glitch", 16'h0001, 16'h0400, 16'h0018, 16'h0400, 1'b1);
    adapter_frame = 32'h0400_0018;
    frame_check("f4", 16'h0018, 16'h0400, 16'h0018, 16'h0400, 1'b1);
    frame_check("f5", 16'h0018, 16'h0400, 16'h0018, 16'h0400, 1'b1);
    check("glitch_seen_on_filtered", 32'(glitch_seen), 32'd0);

    // Unused raw bits 12-15 and 28-31 set.
    adapter_frame = 32'hF123_F005;
    frame_check("f6_hibits", 16'h0005, 16'h0123, 16'h0018, 16'h0400, 1'b1);
    frame_check("f7_hibits", 16'h0005, 16'h0123, 16'h0005, 16'h0123, 1'b1);

    // Data line stuck low: adapter absent.
    stuck_low = 1'b1;
    frame_check("f8_absent", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    frame_check("f9_absent", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    stuck_low = 1'b0;
    // Absent frames leave the filter history intact, so one frame suffices.
    frame_check("f10_back", 16'h0005, 16'h0123, 16'h0005, 16'h0123, 1'b1);

    // Reset in the middle of the HI half of bit 17.
    adapter_frame = 32'h0400_0018;
    n = 0;
    while (!(falls == 18 && s0_state == ST_HI) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_hi_bit17", 32'(falls == 18 && s0_state == ST_HI), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst state", 32'(s0_state), 32'(ST_WAIT));
    check("midrst s1 state", 32'(s1_state), 32'(ST_WAIT));
    check("midrst JOY_CLK", 32'(s0_clk), 32'd1);
    check("midrst JOY_LOAD", 32'(s0_load), 32'd1);
    check("midrst j1", 32'(s0_j1), 32'd0);
    check("midrst j2", 32'(s0_j2), 32'd0);
    check("midrst s1_j1", 32'(s1_j1), 32'd0);
    check("midrst present", 32'(s0_pres), 32'd0);
    reset_n = 1'b1;
    frame_check("f11_after_rst", 16'h0018, 16'h0400, 16'h0000, 16'h0000, 1'b1);
    frame_check("f12_after_rst", 16'h0018, 16'h0400, 16'h0018, 16'h0400, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
